// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb_pkg
// Purpose  : Shared widths, reset values and the rsp_id width derivation.
// Revision : 1.0
// ============================================================================
package adder_arb_pkg;

  localparam int C_ADDER_W      = 4;
  localparam int C_DEFAULT_NREQ = 4;

  localparam logic                 C_RST_VALID = 1'b0;
  localparam logic [C_ADDER_W-1:0] C_RST_SUM   = '0;
  localparam logic                 C_RST_COUT  = 1'b0;

  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/Ripple_Carry_Adder.sv
`default_nettype none
// ============================================================================
// Module   : Ripple_Carry_Adder
// Purpose  : 4-bit ripple-carry adder, {cout,sum} = a + b + cin.
// Revision : 1.0
// ============================================================================
module Ripple_Carry_Adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/adder_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker (priority encoder when
//            ADDER_ARB_FIXED_PRI_EN is defined; the ptr port is then absent).
// Revision : 1.0
// ============================================================================
module rr_pick
  import adder_arb_pkg::*;
#(
  parameter int NREQ = C_DEFAULT_NREQ,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
`ifndef ADDER_ARB_FIXED_PRI_EN
  input  logic [IDW-1:0]  ptr,
`endif
  output logic [NREQ-1:0] winner_oh,
  output logic [IDW-1:0]  winner_idx,
  output logic            any
);

  logic [IDW-1:0] w_k;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any        = 1'b0;
    w_k        = '0;
    for (int off = 0; off < NREQ; off++) begin
`ifdef ADDER_ARB_FIXED_PRI_EN
      w_k = IDW'(off);
`else
      w_k = IDW'((int'(ptr) + off) % NREQ);
`endif
      if (!any && eligible[w_k]) begin
        any            = 1'b1;
        winner_oh[w_k] = 1'b1;
        winner_idx     = w_k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter
// Purpose  : Shares one 4-bit ripple-carry adder among NREQ requesters with a
//            grant/capture stage and a backpressured result stage.
//            ADDER_ARB_FIXED_PRI_EN selects fixed priority (lowest index wins).
// Revision : 1.0
// ============================================================================
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NREQ = C_DEFAULT_NREQ,
  parameter  int W    = C_ADDER_W,
  localparam int IDW  = idw_of(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  input  logic [NREQ-1:0]   cin,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout
);

  if (W != C_ADDER_W) begin : g_bad_width
    $error("adder_share_arbiter: W must equal the shared adder width");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("adder_share_arbiter: NREQ must be in 2..8");
  end

  logic [NREQ-1:0] w_eligible;
  logic [NREQ-1:0] w_win_oh;
  logic [IDW-1:0]  w_win_idx;
  logic            w_any;
  logic            w_stall;
  logic            w_capture;
  logic            w_s1_adv;
  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;
  logic            w_cin_sel;
  logic [W-1:0]    w_sum;
  logic            w_cout;

  logic            r_s1_valid;
  logic [W-1:0]    r_s1_a;
  logic [W-1:0]    r_s1_b;
  logic            r_s1_cin;
  logic [IDW-1:0]  r_s1_id;

  // The current grant holder is masked while it drops its request.
  assign w_eligible = req & ~gnt;
  assign w_stall    = rsp_valid & ~rsp_ready & r_s1_valid;
  assign w_capture  = w_any & ~w_stall;
  assign w_s1_adv   = r_s1_valid & (~rsp_valid | rsp_ready);

`ifndef ADDER_ARB_FIXED_PRI_EN
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_next;

  assign w_ptr_next = (w_win_idx == IDW'(NREQ - 1)) ? '0 : w_win_idx + IDW'(1);
`endif

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .eligible  (w_eligible),
`ifndef ADDER_ARB_FIXED_PRI_EN
    .ptr       (r_ptr),
`endif
    .winner_oh (w_win_oh),
    .winner_idx(w_win_idx),
    .any       (w_any)
  );

  always_comb begin
    w_a_sel   = '0;
    w_b_sel   = '0;
    w_cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_oh[i]) begin
        w_a_sel   = a_flat[i*W +: W];
        w_b_sel   = b_flat[i*W +: W];
        w_cin_sel = cin[i];
      end
    end
  end

  Ripple_Carry_Adder u_adder (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .cin (r_s1_cin),
    .sum (w_sum),
    .cout(w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      rsp_valid  <= C_RST_VALID;
      rsp_id     <= '0;
      rsp_sum    <= C_RST_SUM;
      rsp_cout   <= C_RST_COUT;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_id    <= '0;
`ifndef ADDER_ARB_FIXED_PRI_EN
      r_ptr      <= '0;
`endif
    end else begin
      gnt <= w_capture ? w_win_oh : '0;

      if (w_capture) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_a_sel;
        r_s1_b     <= w_b_sel;
        r_s1_cin   <= w_cin_sel;
        r_s1_id    <= w_win_idx;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Advancing s1 overwrites a result being handed off in the same cycle.
      if (w_s1_adv) begin
        rsp_valid <= 1'b1;
        rsp_id    <= r_s1_id;
        rsp_sum   <= w_sum;
        rsp_cout  <= w_cout;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

`ifndef ADDER_ARB_FIXED_PRI_EN
      if (w_capture) begin
        r_ptr <= w_ptr_next;
      end
`endif
    end
  end

endmodule
`default_nettype wire
